bin_to_bcd_seq: RTL

- Iterative double-dabble converter: binary value in, packed BCD out.
- Sits directly upstream of the 8-digit seven-segment display block; `digits` drives its 32-bit `digits` input (nibble 0 = rightmost digit).
- One shift/add-3 iteration per clock. Result register updates atomically, so the display never shows partial conversions.
- Valid/ready handshake on input; one-cycle `done` pulse on output.

---
 rtl/bin_to_bcd_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one shift/add-3 step per clock,
// valid/ready input handshake, atomically updated result with a one-cycle done pulse.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W    = 27,
  parameter int unsigned N_DIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BIN_W-1:0]        bin_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned BCD_W  = 4 * N_DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W) + 1;

  function automatic logic [63:0] pow10_minus1(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_DEC = pow10_minus1(N_DIGITS);
  // Overflow is only reachable when the binary range exceeds the decimal range.
  localparam bit OVF_POSSIBLE = (BIN_W >= 64) ? 1'b1
                              : (((64'd1 << BIN_W) - 64'd1) > MAX_DEC);
  localparam logic [BIN_W-1:0] MAX_DEC_W = BIN_W'(MAX_DEC);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    digits_q, digits_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [WORK_W-1:0]   adjusted;
  logic [WORK_W-1:0]   stepped;
  logic                ovf_cmp;

  // One double-dabble step: nibble-local add-3, then shift the whole register left.
  always_comb begin
    adjusted = work_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (work_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        adjusted[BIN_W + 4*i +: 4] = work_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    stepped = {adjusted[WORK_W-2:0], 1'b0};
  end

  assign ovf_cmp = OVF_POSSIBLE && (bin_in > MAX_DEC_W);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d     = WORK_W'(bin_in);
          cnt_d      = '0;
          ovf_pend_d = ovf_cmp;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        work_d = stepped;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          digits_d   = ovf_pend_q ? {N_DIGITS{4'h9}} : stepped[WORK_W-1 -: BCD_W];
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign digits   = digits_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule
